apb_req_arbiter: RTL and testbench

//  Shares one APB master port between NUM_REQ local requesters, using round-robin arbitration.

---
 rtl/apb_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ local requesters.
// Each grant runs one SETUP -> ENABLE transfer; the response is returned to the owning client.
module apb_req_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_LIMIT     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          rsp_tmo,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]         pwdata,
    output logic                          pwrite,
    output logic                          psel1,
    output logic                          penable,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pready,
    input  logic                          pslverr
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ENABLE} apb_master_state_t;

    apb_master_state_t     state_q;
    logic [PW-1:0]         ptr_q;
    logic [PW-1:0]         owner_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  range_err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [TW-1:0]         cnt_q;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First requester at or after the pointer, wrapping around.
    logic [PW-1:0]      cand;
    logic [PW-1:0]      win_idx;
    logic               win_found;
    logic [NUM_REQ-1:0] win_onehot;
    logic               win_oor;

    always_comb begin
        cand       = '0;
        win_idx    = '0;
        win_found  = 1'b0;
        win_onehot = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = PW'((32'(ptr_q) + k) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_onehot[win_idx] = 1'b1;
    end

    assign win_oor = 32'(addr_arr[win_idx]) >= ADDR_LIMIT;

    logic          xfer_ok;
    logic          tmo_hit;
    logic          range_done;
    logic          xfer_end;
    logic [PW-1:0] next_ptr;

    assign xfer_ok    = (state_q == ENABLE) && pready;
    assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (state_q == ENABLE) && !pready &&
                        (cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign range_done = (state_q == SETUP) && range_err_q;
    assign xfer_end   = xfer_ok || tmo_hit || range_done;
    assign next_ptr   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);

    // Completion is reported in the cycle the slave answers, so done/rsp_* follow pready.
    assign done      = gnt_q & {NUM_REQ{xfer_end}};
    assign rsp_err   = range_done || tmo_hit || (xfer_ok && pslverr);
    assign rsp_tmo   = tmo_hit;
    assign rsp_rdata = (xfer_ok && !write_q) ? prdata : rdata_q;

    assign gnt     = gnt_q;
    assign paddr   = addr_q;
    assign pwdata  = wdata_q;
    assign pwrite  = write_q;
    assign psel1   = psel_q;
    assign penable = penable_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            range_err_q <= 1'b0;
            rdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q     <= SETUP;
                        owner_q     <= win_idx;
                        gnt_q       <= win_onehot;
                        addr_q      <= addr_arr[win_idx];
                        wdata_q     <= wdata_arr[win_idx];
                        write_q     <= req_write[win_idx];
                        range_err_q <= win_oor;
                        psel_q      <= !win_oor;
                    end
                end
                SETUP: begin
                    if (range_err_q) begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        range_err_q <= 1'b0;
                        ptr_q       <= next_ptr;
                    end else begin
                        state_q   <= ENABLE;
                        penable_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                ENABLE: begin
                    if (xfer_ok || tmo_hit) begin
                        state_q   <= IDLE;
                        gnt_q     <= '0;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        cnt_q     <= '0;
                        ptr_q     <= next_ptr;
                        if (xfer_ok && !write_q) begin
                            rdata_q <= prdata;
                        end
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed vector table, hand sequences for
// round-robin order and mid-transfer reset, and randomized traffic against a transaction model.
module tb_apb_req_arbiter;

    localparam int unsigned NR    = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned LIMIT = 12;
    localparam int unsigned TMO   = 15;

    logic              pclk = 1'b0;
    logic              preset;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              rsp_tmo;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic              pwrite;
    logic              psel1;
    logic              penable;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;

    int checks = 0;
    int errors = 0;

    apb_req_arbiter #(
        .NUM_REQ       (NR),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .ADDR_LIMIT    (LIMIT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .req      (req),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .gnt      (gnt),
        .done     (done),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .rsp_tmo  (rsp_tmo),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pwrite   (pwrite),
        .psel1    (psel1),
        .penable  (penable),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        int         cli;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         waits;
        logic       serr;
        logic [7:0] rd;
        int         exp_done_at;
        int         exp_psel;
        int         exp_pen;
        logic       exp_err;
        logic       exp_tmo;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_client(input int c, input logic w, input logic [3:0] a, input logic [7:0] d);
        req_write[c]       = w;
        req_addr[c*AW +: AW] = a;
        req_wdata[c*DW +: DW] = d;
    endtask

    function automatic int idx_of(input logic [NR-1:0] v);
        idx_of = -1;
        for (int i = NR - 1; i >= 0; i--) if (v[i]) idx_of = i;
    endfunction

    task automatic apply_reset();
        preset  = 1'b1;
        req     = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        repeat (2) @(posedge pclk);
        #4;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_tmo", rsp_tmo, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_psel1", psel1, 0);
        chk("rst_penable", penable, 0);
        preset = 1'b0;
        tick();
    endtask

    // Runs one transfer for a lone requester and records what the bus and response looked like.
    task automatic observe(input vec_t v, output int done_at, output int n_psel, output int n_pen,
                           output logic err, output logic tmo, output logic [7:0] rdata,
                           output logic stable, output logic [NR-1:0] dvec);
        int en_seen;
        done_at = 0; n_psel = 0; n_pen = 0; en_seen = 0;
        err = 1'b0; tmo = 1'b0; rdata = '0; stable = 1'b1; dvec = '0;
        set_client(v.cli, v.wr, v.addr, v.wdata);
        req = NR'(1) << v.cli;
        for (int n = 1; n <= 40; n++) begin
            pready  = (en_seen == v.waits);
            pslverr = v.serr & pready;
            prdata  = pready ? v.rd : ~v.rd;
            #4;
            if (psel1) begin
                n_psel++;
                if (paddr !== v.addr || pwrite !== v.wr || pwdata !== v.wdata) stable = 1'b0;
            end
            if (penable) begin
                n_pen++;
                en_seen++;
            end
            if (done != 0) begin
                done_at = n;
                err     = rsp_err;
                tmo     = rsp_tmo;
                rdata   = rsp_rdata;
                dvec    = done;
                break;
            end
            tick();
        end
        tick();
        req = '0;
    endtask

    // Transaction-level reference state for the random phase.
    int         m_ptr;
    logic       m_pend  [NR];
    logic [3:0] m_addr  [NR];
    logic [7:0] m_wd    [NR];
    logic       m_wr    [NR];
    logic [7:0] last_rd;

    task automatic add_req(input int c);
        m_pend[c] = 1'b1;
        m_addr[c] = 4'($urandom_range(0, 15));
        m_wd[c]   = 8'($urandom);
        m_wr[c]   = 1'($urandom_range(0, 1));
        set_client(c, m_wr[c], m_addr[c], m_wd[c]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         d_at, n_ps, n_pe;
        logic       o_err, o_tmo, o_stable;
        logic [7:0] o_rd;
        logic [NR-1:0] o_dvec;
        int         nd;
        int         dcyc [5];
        int         didx [5];
        int         exp_order [5];
        int         w, waits, any;
        logic       inr, serr, exp_end;
        logic [7:0] rd;

        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;

        //          cli wr   addr   wdata  waits serr  rd     at  psel pen err   tmo   rdata
        vecs[0] = '{0, 1'b1, 4'h3, 8'hA5, 0,  1'b0, 8'h00, 3,  2,  1,  1'b0, 1'b0, 8'h00};
        vecs[1] = '{1, 1'b0, 4'h7, 8'h00, 3,  1'b0, 8'h5C, 6,  5,  4,  1'b0, 1'b0, 8'h5C};
        vecs[2] = '{2, 1'b1, 4'h5, 8'h3C, 1,  1'b1, 8'h77, 4,  3,  2,  1'b1, 1'b0, 8'h5C};
        vecs[3] = '{3, 1'b0, 4'hC, 8'h00, 0,  1'b0, 8'h99, 2,  0,  0,  1'b1, 1'b0, 8'h5C};
        vecs[4] = '{0, 1'b0, 4'h2, 8'h00, 99, 1'b0, 8'h11, 17, 16, 15, 1'b1, 1'b1, 8'h5C};
        vecs[5] = '{1, 1'b0, 4'hB, 8'h00, 0,  1'b0, 8'h3E, 3,  2,  1,  1'b0, 1'b0, 8'h3E};

        apply_reset();

        for (int i = 0; i < 6; i++) begin
            observe(vecs[i], d_at, n_ps, n_pe, o_err, o_tmo, o_rd, o_stable, o_dvec);
            chk($sformatf("v%0d_done_at", i), d_at, vecs[i].exp_done_at);
            chk($sformatf("v%0d_psel_cycles", i), n_ps, vecs[i].exp_psel);
            chk($sformatf("v%0d_penable_cycles", i), n_pe, vecs[i].exp_pen);
            chk($sformatf("v%0d_done_owner", i), o_dvec, NR'(1) << vecs[i].cli);
            chk($sformatf("v%0d_err", i), o_err, vecs[i].exp_err);
            chk($sformatf("v%0d_tmo", i), o_tmo, vecs[i].exp_tmo);
            chk($sformatf("v%0d_rdata", i), o_rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_bus_stable", i), o_stable, 1);
        end

        // Reset while waiting in ENABLE.
        set_client(2, 1'b1, 4'h6, 8'h42);
        req    = 4'b0100;
        pready = 1'b0;
        tick();
        tick();
        #1;
        chk("t6_in_enable", {psel1, penable}, 2'b11);
        #1;
        preset = 1'b1;
        #1;
        chk("t6_psel_async", psel1, 0);
        chk("t6_penable_async", penable, 0);
        chk("t6_gnt_async", gnt, 0);
        chk("t6_done_async", done, 0);
        req = '0;
        tick();
        tick();
        #3;
        chk("t6_no_done", done, 0);
        preset = 1'b0;
        tick();

        // All four clients hold req: order must restart at client 0 and rotate.
        for (int c = 0; c < NR; c++) set_client(c, 1'b1, 4'(c), 8'(c + 16));
        req = 4'b1111; pready = 1'b1; pslverr = 1'b0;
        nd = 0;
        for (int n = 1; n <= 40 && nd < 5; n++) begin
            #4;
            chk("t3_gnt_onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
            if (done != 0) begin
                dcyc[nd] = n;
                didx[nd] = idx_of(done);
                nd++;
            end
            tick();
        end
        req = '0;
        #4;
        chk("t3_idle_gnt", gnt, 0);
        chk("t3_idle_psel", psel1, 0);
        chk("t3_done_count", nd, 5);
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < nd; k++) begin
            chk($sformatf("t3_order%0d", k), didx[k], exp_order[k]);
            chk($sformatf("t3_done_cycle%0d", k), dcyc[k], 3 * (k + 1));
        end
        tick();

        // Randomized traffic against the transaction model.
        apply_reset();
        m_ptr = 0;
        last_rd = '0;
        for (int c = 0; c < NR; c++) m_pend[c] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            any = 0;
            for (int c = 0; c < NR; c++) begin
                if (!m_pend[c] && $urandom_range(0, 2) == 0) add_req(c);
                if (m_pend[c]) any = 1;
            end
            if (any == 0) add_req(int'($urandom_range(0, NR - 1)));
            for (int c = 0; c < NR; c++) req[c] = m_pend[c];
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = 8'($urandom);
            #4;
            chk("r_idle", {gnt, psel1, penable, done}, 0);
            chk("r_idle_rdata", rsp_rdata, last_rd);

            w = -1;
            for (int k = 0; k < NR; k++)
                if (w < 0 && m_pend[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            inr = (m_addr[w] < LIMIT);

            tick();
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            #4;
            chk("r_setup_gnt", gnt, NR'(1) << w);
            chk("r_setup_psel", {psel1, penable}, {inr, 1'b0});
            if (!inr) begin
                chk("r_range_done", done, NR'(1) << w);
                chk("r_range_err", {rsp_err, rsp_tmo}, 2'b10);
                m_ptr = (w + 1) % NR;
                m_pend[w] = 1'b0;
                tick();
                continue;
            end
            chk("r_setup_done", done, 0);
            chk("r_setup_bus", {paddr, pwrite, pwdata}, {m_addr[w], m_wr[w], m_wd[w]});

            case ($urandom_range(0, 11))
                0:       waits = 100;
                1:       waits = TMO - 1;
                default: waits = int'($urandom_range(0, 3));
            endcase
            serr = ($urandom_range(0, 3) == 0);
            rd   = 8'($urandom);
            tick();
            for (int c = 0; c < 40; c++) begin
                pready  = (c == waits);
                pslverr = (c == waits) ? serr : 1'($urandom_range(0, 1));
                prdata  = (c == waits) ? rd : 8'($urandom);
                #4;
                exp_end = (c == waits) || (c == TMO - 1);
                chk("r_en_bus", {psel1, penable, paddr, pwrite, pwdata},
                    {2'b11, m_addr[w], m_wr[w], m_wd[w]});
                chk("r_en_gnt", gnt, NR'(1) << w);
                chk("r_en_done", done, exp_end ? (NR'(1) << w) : NR'(0));
                if (exp_end) begin
                    if (c == waits && !m_wr[w]) last_rd = rd;
                    chk("r_err", rsp_err, (c == waits) ? serr : 1'b1);
                    chk("r_tmo", rsp_tmo, (c != waits));
                    chk("r_rdata", rsp_rdata, last_rd);
                    break;
                end
                tick();
            end
            m_ptr = (w + 1) % NR;
            m_pend[w] = 1'b0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
